// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN back-end constants, FSM state type and round-up helper
package cnn_pkg;

    // Default word format: unsigned fixed point after ReLU.
    localparam int CNN_DATA_W = 20;
    localparam int CNN_FRAC_W = 16;

    // Bank select encoding. 0 means no bank is addressed.
    localparam int CSEL_NONE = 0;
    localparam int CSEL_L0   = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_DRAIN,
        S_WR_L1,
        S_WR_L2,
        S_FIN
    } state_t;

    // Layer-1 banks follow the CH layer-0 banks; layer 2 follows those.
    function automatic int csel_l1_base(input int ch_count);
        return CSEL_L0 + ch_count;
    endfunction

    function automatic int csel_l2(input int ch_count);
        return CSEL_L0 + 2 * ch_count;
    endfunction

    // Ceil to the next integer when any fraction bit is set; an integer
    // part that would overflow data_w saturates to all ones.
    function automatic logic [63:0] round_up_sat(input logic [63:0] x,
                                                 input int data_w,
                                                 input int frac_w);
        logic [63:0] fmask;
        logic [63:0] wmask;
        logic [63:0] r;
        fmask = (64'd1 << frac_w) - 64'd1;
        wmask = (64'd1 << data_w) - 64'd1;
        if ((x & fmask) == 64'd0) begin
            r = x;
        end else begin
            r = ((x >> frac_w) + 64'd1) << frac_w;
            if (r > wmask) begin
                r = wmask;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pool_flatten_engine_addr_gen.sv
// rtl/pool_flatten_engine_addr_gen.sv - tap/window/channel counters and address generation
//
// Module pool_addr_gen
//   clk, reset   clock, asynchronous active-high reset
//   clear        hold all counters at zero
//   tap_step     advance to the next tap of the window (dx fastest, wraps)
//   win_step     advance ch, then wx, then wy; taps return to zero
//   rd_addr      layer-0 address of the current tap
//   l1_addr      layer-1 address of the current window
//   l2_addr      layer-2 (channel-interleaved) address of window/channel
//   ch           current channel
//   last_tap     current tap is the final one of the window
//   last_window  current window is the bottom-right one
//   last_ch      current channel is the final one
module pool_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int POOL   = 2,
    parameter int CH     = 2,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              tap_step,
    input  logic              win_step,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] l1_addr,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [1:0]        ch,
    output logic              last_tap,
    output logic              last_window,
    output logic              last_ch
);

    localparam int WN = IMG_W / POOL;
    localparam int PW = $clog2(POOL);
    localparam int WW = $clog2(WN);

    logic [PW-1:0] dx, dy;
    logic [WW-1:0] wx, wy;
    logic [1:0]    ch_q;

    logic dx_last, dy_last, wx_last, wy_last;

    assign dx_last     = (dx == PW'(POOL - 1));
    assign dy_last     = (dy == PW'(POOL - 1));
    assign wx_last     = (wx == WW'(WN - 1));
    assign wy_last     = (wy == WW'(WN - 1));
    assign last_tap    = dx_last && dy_last;
    assign last_window = wx_last && wy_last;
    assign last_ch     = (ch_q == 2'(CH - 1));
    assign ch          = ch_q;

    assign rd_addr = ADDR_W'((int'(wy) * POOL + int'(dy)) * IMG_W + int'(wx) * POOL + int'(dx));
    assign l1_addr = ADDR_W'(int'(wy) * WN + int'(wx));
    assign l2_addr = ADDR_W'((int'(wy) * WN + int'(wx)) * CH + int'(ch_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx   <= '0;
            dy   <= '0;
            wx   <= '0;
            wy   <= '0;
            ch_q <= '0;
        end else if (clear) begin
            dx   <= '0;
            dy   <= '0;
            wx   <= '0;
            wy   <= '0;
            ch_q <= '0;
        end else if (win_step) begin
            dx <= '0;
            dy <= '0;
            if (last_ch) begin
                ch_q <= '0;
                if (wx_last) begin
                    wx <= '0;
                    wy <= wy_last ? '0 : wy + 1'b1;
                end else begin
                    wx <= wx + 1'b1;
                end
            end else begin
                ch_q <= ch_q + 2'd1;
            end
        end else if (tap_step) begin
            if (dx_last) begin
                dx <= '0;
                dy <= dy_last ? '0 : dy + 1'b1;
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_flatten_engine.sv
// rtl/pool_flatten_engine.sv - max-pool CH feature maps and write pooled maps plus flatten vector
//
// Ports
//   clk, reset  clock, asynchronous active-high reset
//   start       one-cycle pulse, accepted only when idle
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle pulse after the final layer-2 write
//   crd         memory read strobe, caddr_rd read address
//   cdata_rd    read data, sampled one cycle after the memory saw crd
//   cwr         memory write strobe, caddr_wr / cdata_wr write address and data
//   csel        bank select shared by reads and writes
module pool_flatten_engine
    import cnn_pkg::*;
#(
    parameter int DATA_W   = CNN_DATA_W,
    parameter int FRAC_W   = CNN_FRAC_W,
    parameter int IMG_W    = 64,
    parameter int POOL     = 2,
    parameter int CH       = 2,
    parameter int ADDR_W   = 12,
    parameter int ROUND_UP = 1,
    parameter int CSEL_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic [CSEL_W-1:0] csel
);

    state_t state;

    logic [ADDR_W-1:0] rd_addr, l1_addr, l2_addr;
    logic [1:0]        ch;
    logic              last_tap, last_window, last_ch;
    logic              tap_step, win_step, clear;

    logic [DATA_W-1:0] max_q, max_nxt, rounded;
    logic              first_q;     // next returned word seeds the max
    logic              cap_v;       // cdata_rd carries a requested word this cycle
    logic              issue_done;  // every tap of the window has been issued
    logic              fin_flag;    // window being written is the last one

    pool_addr_gen #(
        .IMG_W  (IMG_W),
        .POOL   (POOL),
        .CH     (CH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .tap_step    (tap_step),
        .win_step    (win_step),
        .rd_addr     (rd_addr),
        .l1_addr     (l1_addr),
        .l2_addr     (l2_addr),
        .ch          (ch),
        .last_tap    (last_tap),
        .last_window (last_window),
        .last_ch     (last_ch)
    );

    // Counters always point at the next tap to issue; the window advances
    // while layer 2 is written so the following RD starts on tap 0.
    always_comb begin
        clear    = (state == S_IDLE) && !start;
        tap_step = ((state == S_IDLE) && start)
                || ((state == S_RD) && !issue_done)
                || ((state == S_WR_L2) && !fin_flag);
        win_step = (state == S_WR_L1);
    end

    // The last word returns in DRAIN, so the written value is taken from
    // the max including the word arriving this cycle.
    always_comb begin
        max_nxt = max_q;
        if (cap_v && (first_q || (cdata_rd > max_q))) begin
            max_nxt = cdata_rd;
        end
    end

    always_comb begin
        rounded = max_nxt;
        if (ROUND_UP != 0) begin
            rounded = DATA_W'(round_up_sat(64'(max_nxt), DATA_W, FRAC_W));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            crd        <= 1'b0;
            cwr        <= 1'b0;
            csel       <= '0;
            caddr_rd   <= '0;
            caddr_wr   <= '0;
            cdata_wr   <= '0;
            max_q      <= '0;
            first_q    <= 1'b1;
            cap_v      <= 1'b0;
            issue_done <= 1'b0;
            fin_flag   <= 1'b0;
        end else begin
            cap_v <= crd;
            max_q <= max_nxt;
            if (cap_v) begin
                first_q <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= S_RD;
                        busy       <= 1'b1;
                        crd        <= 1'b1;
                        csel       <= CSEL_W'(CSEL_L0 + int'(ch));
                        caddr_rd   <= rd_addr;
                        issue_done <= last_tap;
                        fin_flag   <= 1'b0;
                        first_q    <= 1'b1;
                    end
                end
                S_RD: begin
                    if (issue_done) begin
                        crd        <= 1'b0;
                        issue_done <= 1'b0;
                        state      <= S_DRAIN;
                    end else begin
                        caddr_rd   <= rd_addr;
                        issue_done <= last_tap;
                    end
                end
                S_DRAIN: begin
                    cwr      <= 1'b1;
                    csel     <= CSEL_W'(csel_l1_base(CH) + int'(ch));
                    caddr_wr <= l1_addr;
                    cdata_wr <= rounded;
                    first_q  <= 1'b1;
                    state    <= S_WR_L1;
                end
                S_WR_L1: begin
                    csel     <= CSEL_W'(csel_l2(CH));
                    caddr_wr <= l2_addr;
                    fin_flag <= last_window && last_ch;
                    state    <= S_WR_L2;
                end
                S_WR_L2: begin
                    cwr <= 1'b0;
                    if (fin_flag) begin
                        csel  <= CSEL_W'(CSEL_NONE);
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        crd        <= 1'b1;
                        csel       <= CSEL_W'(CSEL_L0 + int'(ch));
                        caddr_rd   <= rd_addr;
                        issue_done <= last_tap;
                        state      <= S_RD;
                    end
                end
                S_FIN: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    fin_flag <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_flatten_engine.sv
// tb/tb_pool_flatten_engine.sv - scoreboard bench for pool_flatten_engine (default and 16x16/POOL4/CH3 builds)
module tb_pool_flatten_engine;

    typedef struct packed {
        logic [2:0]  sel;
        logic [11:0] addr;
        logic [19:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: 64x64, POOL 2, CH 2, no round-up
    logic        rst0, start0, busy0, done0, crd0, cwr0;
    logic [11:0] ard0, awr0;
    logic [19:0] rd0, wd0;
    logic [2:0]  csel0;
    // dut1: 16x16, POOL 4, CH 3, round-up
    logic        rst1, start1, busy1, done1, crd1, cwr1;
    logic [11:0] ard1, awr1;
    logic [19:0] rd1, wd1;
    logic [2:0]  csel1;

    pool_flatten_engine #(.DATA_W(20), .FRAC_W(16), .IMG_W(64), .POOL(2), .CH(2),
                          .ADDR_W(12), .ROUND_UP(0), .CSEL_W(3)) dut0 (
        .clk(clk), .reset(rst0), .start(start0), .busy(busy0), .done(done0),
        .crd(crd0), .caddr_rd(ard0), .cdata_rd(rd0), .cwr(cwr0),
        .caddr_wr(awr0), .cdata_wr(wd0), .csel(csel0));

    pool_flatten_engine #(.DATA_W(20), .FRAC_W(16), .IMG_W(16), .POOL(4), .CH(3),
                          .ADDR_W(12), .ROUND_UP(1), .CSEL_W(3)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .busy(busy1), .done(done1),
        .crd(crd1), .caddr_rd(ard1), .cdata_rd(rd1), .cwr(cwr1),
        .caddr_wr(awr1), .cdata_wr(wd1), .csel(csel1));

    logic [19:0] m0_l0 [0:1][0:4095];
    logic [19:0] m0_l1 [0:1][0:1023];
    logic [19:0] m0_l2 [0:2047];
    logic [19:0] m1_l0 [0:2][0:255];
    logic [19:0] m1_l1 [0:2][0:15];
    logic [19:0] m1_l2 [0:47];

    wr_t sb0[$];
    wr_t sb1[$];
    int  checks = 0;
    int  failures = 0;
    int  done_cnt0 = 0;
    int  done_cnt1 = 0;
    logic prev_crd0 = 1'b0;
    logic prev_crd1 = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Memory models: read data appears one edge after the strobe is seen.
    always @(posedge clk) begin
        if (crd0 && csel0 >= 3'd1 && csel0 <= 3'd2) rd0 <= m0_l0[int'(csel0) - 1][ard0];
        if (cwr0) begin
            if (csel0 == 3'd3 || csel0 == 3'd4) m0_l1[int'(csel0) - 3][awr0[9:0]] <= wd0;
            else if (csel0 == 3'd5) m0_l2[awr0[10:0]] <= wd0;
        end
        if (crd1 && csel1 >= 3'd1 && csel1 <= 3'd3) rd1 <= m1_l0[int'(csel1) - 1][ard1[7:0]];
        if (cwr1) begin
            if (csel1 >= 3'd4 && csel1 <= 3'd6) m1_l1[int'(csel1) - 4][awr1[3:0]] <= wd1;
            else if (csel1 == 3'd7 && awr1 < 12'd48) m1_l2[awr1[5:0]] <= wd1;
        end
    end

    // Write monitors and protocol checks.
    always @(negedge clk) begin
        wr_t e;
        logic bad;
        if (cwr0) begin
            if (sb0.size() == 0) check("sb0_unexpected_write", {csel0, awr0, wd0}, 0);
            else begin e = sb0.pop_front(); check("wr0", {csel0, awr0, wd0}, e); end
        end
        if (cwr1) begin
            if (sb1.size() == 0) check("sb1_unexpected_write", {csel1, awr1, wd1}, 0);
            else begin e = sb1.pop_front(); check("wr1", {csel1, awr1, wd1}, e); end
        end
        if (!rst0) begin
            bad = (crd0 && cwr0) || (crd0 && !(csel0 inside {3'd1, 3'd2}))
               || (cwr0 && !(csel0 inside {3'd3, 3'd4, 3'd5}))
               || (!crd0 && !cwr0 && !prev_crd0 && csel0 != 3'd0);
            check("proto0", bad, 0);
        end
        if (!rst1) begin
            bad = (crd1 && cwr1) || (crd1 && !(csel1 inside {3'd1, 3'd2, 3'd3}))
               || (crd1 && ard1 >= 12'd256)
               || (cwr1 && !(csel1 inside {3'd4, 3'd5, 3'd6, 3'd7}))
               || (!crd1 && !cwr1 && !prev_crd1 && csel1 != 3'd0);
            check("proto1", bad, 0);
        end
        prev_crd0 = crd0;
        prev_crd1 = crd1;
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    function automatic logic [19:0] rnd(input logic [19:0] x, input int ru);
        logic [20:0] v;
        if (ru == 0 || x[15:0] == 16'd0) return x;
        v = ({17'd0, x[19:16]} + 21'd1) << 16;
        if (v > 21'hFFFFF) return 20'hFFFFF;
        return v[19:0];
    endfunction

    task automatic build_exp(input int d);
        int img, p, nch, wn, a, win;
        logic [19:0] mx, v;
        img = d ? 16 : 64; p = d ? 4 : 2; nch = d ? 3 : 2; wn = img / p;
        for (int wy = 0; wy < wn; wy++)
            for (int wx = 0; wx < wn; wx++)
                for (int c = 0; c < nch; c++) begin
                    mx = 20'd0;
                    for (int dy = 0; dy < p; dy++)
                        for (int dx = 0; dx < p; dx++) begin
                            a = (wy * p + dy) * img + wx * p + dx;
                            v = d ? m1_l0[c][a] : m0_l0[c][a];
                            if (v > mx) mx = v;
                        end
                    mx = rnd(mx, d);
                    win = wy * wn + wx;
                    if (d) begin
                        sb1.push_back({3'(1 + nch + c), 12'(win), mx});
                        sb1.push_back({3'(1 + 2 * nch), 12'(win * nch + c), mx});
                    end else begin
                        sb0.push_back({3'(1 + nch + c), 12'(win), mx});
                        sb0.push_back({3'(1 + 2 * nch), 12'(win * nch + c), mx});
                    end
                end
    endtask

    task automatic set_start(input int d, input logic v);
        if (d) start1 = v; else start0 = v;
    endtask

    task automatic run_pass(input int d, input int exp_cyc, input int mid_start);
        int cyc, dc;
        dc = d ? done_cnt1 : done_cnt0;
        @(negedge clk); set_start(d, 1'b1);
        @(negedge clk); set_start(d, 1'b0);
        cyc = 0;
        while (!(d ? done1 : done0) && cyc < exp_cyc + 50) begin
            @(negedge clk);
            cyc++;
            if (cyc == mid_start) set_start(d, 1'b1);
            else if (cyc == mid_start + 1) set_start(d, 1'b0);
            if (cyc == 10) check(d ? "busy_run1" : "busy_run0", d ? busy1 : busy0, 1);
        end
        check_range(d ? "done_latency1" : "done_latency0", cyc, exp_cyc, exp_cyc + 2);
        repeat (20) @(negedge clk);
        check(d ? "done_once1" : "done_once0", (d ? done_cnt1 : done_cnt0) - dc, 1);
        check(d ? "busy_after1" : "busy_after0", d ? busy1 : busy0, 0);
        check(d ? "sb_left1" : "sb_left0", d ? sb1.size() : sb0.size(), 0);
    endtask

    task automatic clear_out0();
        for (int c = 0; c < 2; c++) for (int a = 0; a < 1024; a++) m0_l1[c][a] = 20'h5A5A5;
        for (int a = 0; a < 2048; a++) m0_l2[a] = 20'h5A5A5;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        rd0 = '0; rd1 = '0;
        for (int c = 0; c < 2; c++) for (int a = 0; a < 4096; a++) m0_l0[c][a] = 20'd0;
        for (int c = 0; c < 3; c++) for (int a = 0; a < 256; a++) m1_l0[c][a] = 20'd0;
        for (int c = 0; c < 3; c++) for (int a = 0; a < 16; a++) m1_l1[c][a] = 20'h5A5A5;
        for (int a = 0; a < 48; a++) m1_l2[a] = 20'h5A5A5;
        clear_out0();
        repeat (3) @(negedge clk);
        check("reset_out0", {busy0, done0, crd0, cwr0, csel0, ard0, awr0, wd0}, 0);
        check("reset_out1", {busy1, done1, crd1, cwr1, csel1, ard1, awr1, wd1}, 0);
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (2) @(negedge clk);

        // All-zero maps.
        build_exp(0);
        run_pass(0, 2048 * 7, -1);
        check("t1_l1c1_last", m0_l1[1][1023], 20'h0);
        check("t1_l2_last", m0_l2[2047], 20'h0);

        // Ramp maps, stray start mid-pass.
        for (int a = 0; a < 4096; a++) begin
            m0_l0[0][a] = 20'(a << 16);
            m0_l0[1][a] = 20'((4095 - a) << 16);
        end
        clear_out0();
        build_exp(0);
        run_pass(0, 2048 * 7, 100);
        check("t2_l1c0_0", m0_l1[0][0], 20'h10000);
        check("t2_l1c1_0", m0_l1[1][0], 20'hF0000);
        check("t2_l2_0", m0_l2[0], 20'h10000);
        check("t2_l2_1", m0_l2[1], 20'hF0000);

        // Abort mid-pass, then a clean rerun.
        clear_out0();
        build_exp(0);
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (500) @(negedge clk);
        rst0 = 1'b1;
        #1;
        check("abort_out0", {busy0, done0, crd0, cwr0, csel0, ard0, awr0, wd0}, 0);
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        sb0.delete();
        clear_out0();
        build_exp(0);
        run_pass(0, 2048 * 7, -1);
        check("t5_l1c0_0", m0_l1[0][0], 20'h10000);
        check("t5_l2_2046", m0_l2[2046], 20'hF0000);
        check("t5_l2_2047", m0_l2[2047], 20'h10000);

        // Small build: round-up, saturation, three-way interleave.
        for (int a = 0; a < 256; a++) begin
            m1_l0[0][a] = (a == 0) ? 20'h18000 : 20'h00100;
            m1_l0[1][a] = 20'h30000;
            m1_l0[2][a] = (a == 17) ? 20'hFFFFF : 20'h00000;
        end
        build_exp(1);
        run_pass(1, 16 * 3 * 19, 200);
        check("t3_l1c0_0", m1_l1[0][0], 20'h20000);
        check("t3_l1c0_1", m1_l1[0][1], 20'h10000);
        check("t3_l1c1_5", m1_l1[1][5], 20'h30000);
        check("t3_l1c2_0", m1_l1[2][0], 20'hFFFFF);
        check("t3_l1c2_3", m1_l1[2][3], 20'h00000);
        check("t6_l2_0", m1_l2[0], 20'h20000);
        check("t6_l2_1", m1_l2[1], 20'h30000);
        check("t6_l2_2", m1_l2[2], 20'hFFFFF);
        check("t6_l2_3", m1_l2[3], 20'h10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
